button_shaper_multi: RTL

Parametrised multi-channel successor to the single-button shaper. Each channel takes an active-low, asynchronous push-button input and applies a 2-flop synchroniser and a counter-based debouncer. A per-channel FSM then emits exactly one Clk-wide pulse per press, with optional auto-repeat while the button is held. The block sits between the board buttons and the passcode/keypad logic and replaces per-button shaper instances.

---
 rtl/button_shaper_multi.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/button_shaper_multi.sv
// ============================================================================
// button_shaper_multi : per-channel 2-flop sync, counter debounce and
//                       press-pulse FSM with optional auto-repeat.
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_shaper_multi #(
  parameter int NUM_BTN      = 4,
  parameter int DB_CYCLES    = 16,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               En,
  input  logic               Rep_en,
  input  logic [NUM_BTN-1:0] Btn_in,
  output logic [NUM_BTN-1:0] Pulse_out,
  output logic [NUM_BTN-1:0] Held_out,
  output logic               Any_pulse
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RC_W   = $clog2(RC_MAX);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DB_CYCLES);
  localparam logic [RC_W-1:0] DELAY_LAST = RC_W'(REPEAT_DELAY - 2);
  localparam logic [RC_W-1:0] RATE_LAST  = RC_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_ON1  = 2'd1,
    S_HOLD = 2'd2,
    S_REP  = 2'd3
  } state_t;

  logic [NUM_BTN-1:0] pulse_nxt;
  logic [NUM_BTN-1:0] held_nxt;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic            sync1;
    logic            sync2;
    logic            db;
    logic            db_prev;
    logic [DB_W-1:0] cnt;
    logic [RC_W-1:0] rc;
    logic [RC_W-1:0] rc_nxt;
    logic            press;
    logic            pulse_c;
    state_t          state;
    state_t          state_nxt;

    // Debounced level resets to released, so a button held across reset
    // is seen as a fresh press once it has been stable for DB_CYCLES.
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        sync1   <= 1'b1;
        sync2   <= 1'b1;
        db      <= 1'b1;
        db_prev <= 1'b1;
        cnt     <= '0;
        state   <= S_OFF;
        rc      <= '0;
      end else begin
        sync1   <= Btn_in[i];
        sync2   <= sync1;
        db_prev <= db;
        if (sync2 == db) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          db  <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        state <= state_nxt;
        rc    <= rc_nxt;
      end
    end

    assign press = db_prev & ~db;

    always_comb begin
      state_nxt = state;
      rc_nxt    = rc;
      pulse_c   = 1'b0;
      if (!En || db) begin
        state_nxt = S_OFF;
        rc_nxt    = '0;
      end else begin
        case (state)
          S_OFF: begin
            if (press) begin
              state_nxt = S_ON1;
              rc_nxt    = '0;
              pulse_c   = 1'b1;
            end
          end
          S_ON1: begin
            state_nxt = S_HOLD;
            rc_nxt    = '0;
          end
          S_HOLD: begin
            // Counter freezes while repeat is disabled.
            if (Rep_en) begin
              if (rc == DELAY_LAST) begin
                state_nxt = S_REP;
                rc_nxt    = '0;
                pulse_c   = 1'b1;
              end else begin
                rc_nxt = rc + 1'b1;
              end
            end
          end
          S_REP: begin
            if (!Rep_en) begin
              state_nxt = S_HOLD;
              rc_nxt    = '0;
            end else if (rc == RATE_LAST) begin
              rc_nxt  = '0;
              pulse_c = 1'b1;
            end else begin
              rc_nxt = rc + 1'b1;
            end
          end
          default: begin
            state_nxt = S_OFF;
            rc_nxt    = '0;
          end
        endcase
      end
    end

    assign pulse_nxt[i] = pulse_c;
    assign held_nxt[i]  = ~db;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Pulse_out <= '0;
      Held_out  <= '0;
      Any_pulse <= 1'b0;
    end else begin
      Pulse_out <= pulse_nxt;
      Held_out  <= held_nxt;
      Any_pulse <= |pulse_nxt;
    end
  end

endmodule

`default_nettype wire
